// File: rtl/q_8_9_datapath_if.sv
// q_8_9_datapath_if: command/status bundle between the q_8_9 controller (master) and its datapath (slave).
//   master drives clr_A_F, incr_A, clr_E, set_E, set_F and observes A, A3, A2, E, F, wrap, e_count, cmd_err.
interface q_8_9_datapath_if #(
  parameter int A_WIDTH   = 4,
  parameter int CNT_WIDTH = 8
);
  logic                 clr_A_F;
  logic                 incr_A;
  logic                 clr_E;
  logic                 set_E;
  logic                 set_F;
  logic [A_WIDTH-1:0]   A;
  logic                 A3;
  logic                 A2;
  logic                 E;
  logic                 F;
  logic                 wrap;
  logic [CNT_WIDTH-1:0] e_count;
  logic                 cmd_err;
  modport master (
    output clr_A_F, incr_A, clr_E, set_E, set_F,
    input  A, A3, A2, E, F, wrap, e_count, cmd_err
  );
  modport slave (
    input  clr_A_F, incr_A, clr_E, set_E, set_F,
    output A, A3, A2, E, F, wrap, e_count, cmd_err
  );
endinterface

// File: rtl/q_8_9_datapath.sv
// q_8_9_datapath: register A and flip-flops E/F driven by q_8_9 one-hot commands, with wrap/event/conflict observability.
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : slave side of q_8_9_datapath_if (commands in; A, A3, A2, E, F, wrap, e_count, cmd_err out)
module q_8_9_datapath #(
  parameter int A_WIDTH   = 4,
  parameter int HI_TAP    = 3,
  parameter int LO_TAP    = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  q_8_9_datapath_if.slave  bus
);
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic                 e_q, e_d;
  logic                 f_q, f_d;
  logic                 wrap_q, wrap_d;
  logic [CNT_WIDTH-1:0] e_count_q, e_count_d;
  logic                 cmd_err_q, cmd_err_d;
  always_comb begin
    a_d       = bus.clr_A_F ? '0 : bus.incr_A ? a_q + A_WIDTH'(1) : a_q;
    f_d       = bus.clr_A_F ? 1'b0 : bus.set_F ? 1'b1 : f_q;
    // set and clear together cancel out, leaving E unchanged
    e_d       = (bus.set_E ^ bus.clr_E) ? bus.set_E : e_q;
    wrap_d    = !bus.clr_A_F && bus.incr_A && (&a_q);
    e_count_d = (bus.set_E && !bus.clr_E && !(&e_count_q)) ? e_count_q + CNT_WIDTH'(1) : e_count_q;
    cmd_err_d = cmd_err_q | (bus.set_E & bus.clr_E) | (bus.clr_A_F & bus.incr_A) | (bus.clr_A_F & bus.set_F);
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q       <= '0;
      e_q       <= 1'b0;
      f_q       <= 1'b0;
      wrap_q    <= 1'b0;
      e_count_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      e_q       <= e_d;
      f_q       <= f_d;
      wrap_q    <= wrap_d;
      e_count_q <= e_count_d;
      cmd_err_q <= cmd_err_d;
    end
  end
  assign bus.A       = a_q;
  assign bus.A3      = a_q[HI_TAP];
  assign bus.A2      = a_q[LO_TAP];
  assign bus.E       = e_q;
  assign bus.F       = f_q;
  assign bus.wrap    = wrap_q;
  assign bus.e_count = e_count_q;
  assign bus.cmd_err = cmd_err_q;
endmodule
